// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types for the IFU PC redirect controller:
// FSM states, redirect source codes and the source-to-flush mapping.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    PRC_RUN  = 2'd0,
    PRC_WAIT = 2'd1,
    PRC_HALT = 2'd2
  } prc_state_e;

  // Numeric order is priority order: a larger code wins.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ID   = 2'd1,
    SRC_EX   = 2'd2,
    SRC_TRAP = 2'd3
  } src_e;

  localparam logic TRUE         = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  // Returns {flush_if_id, flush_id_ex} for an accepted source.
  function automatic logic [1:0] src_flush(src_e s);
    logic [1:0] f;
    f = 2'b00;
    unique case (s)
      SRC_TRAP, SRC_EX: f = 2'b11;
      SRC_ID:           f = 2'b10;
      default:          f = 2'b00;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/pc_target_check.sv
// Combinational legality check of a redirect target.
// Ports: target in; fault, final_target out. Macro PC_ALIGN_CHECK_EN adds alignment faults.
module pc_target_check
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR    = '0,
  parameter logic [XLEN-1:0] IT_RAM_DEPTH = 32'h1000,
  parameter logic [XLEN-1:0] TRAP_VEC     = BOOT_ADDR
) (
  input  logic [XLEN-1:0] target,
  output logic            fault,
  output logic [XLEN-1:0] final_target
);

  // One extra bit so BOOT_ADDR+IT_RAM_DEPTH cannot wrap.
  localparam logic [XLEN:0] LO = {1'b0, BOOT_ADDR};
  localparam logic [XLEN:0] HI = {1'b0, BOOT_ADDR} + {1'b0, IT_RAM_DEPTH};

  logic [XLEN:0] t_ext;
  logic          range_bad;

  assign t_ext     = {1'b0, target};
  assign range_bad = (t_ext < LO) || (t_ext >= HI);

`ifdef PC_ALIGN_CHECK_EN
  assign fault        = range_bad || (target[1:0] != 2'b00);
  assign final_target = fault ? TRAP_VEC : target;
`else
  assign fault        = range_bad;
  assign final_target = fault ? TRAP_VEC
                              : {target[XLEN-1:2], 2'b00};
`endif

endmodule

// File: rtl/pc_redirect_ctrl.sv
// IFU PC sequencer: arbitrates trap/EX/ID redirects, stalls and halt into pc_reg controls.
// Ports: clk, rst(n), stall/redirect/halt inputs; pc write/hold, flushes, fault, halted out. Macro: PC_ALIGN_CHECK_EN.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR    = '0,
  parameter logic [XLEN-1:0] IT_RAM_DEPTH = 32'h1000,
  parameter logic [XLEN-1:0] TRAP_VEC     = BOOT_ADDR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_ready,
  input  logic            load_hazard,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            ex_br_take,
  input  logic [XLEN-1:0] ex_br_addr,
  input  logic            id_jmp_take,
  input  logic [XLEN-1:0] id_jmp_addr,
  input  logic            halt_req,
  input  logic            resume,
  output logic            pc_write_flag,
  output logic [XLEN-1:0] pc_write_addr,
  output logic            pc_hold,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr,
  output logic            halted
);

  prc_state_e      state_q, state_d;
  src_e            pend_src_q, pend_src_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic [XLEN-1:0] fault_addr_q;

  src_e            cand_src;
  logic [XLEN-1:0] cand_addr;
  src_e            eff_src;
  logic [XLEN-1:0] eff_addr;
  logic            take_new;
  logic            halt_go;
  logic            write;
  logic            hold;
  logic [1:0]      flush;
  logic [XLEN-1:0] issue_addr;
  logic            chk_fault;
  logic [XLEN-1:0] chk_target;

  // An ID jump under a load hazard is not presented;
  // ID re-offers it once the hazard clears.
  always_comb begin
    cand_src  = SRC_NONE;
    cand_addr = '0;
    if (trap_req) begin
      cand_src  = SRC_TRAP;
      cand_addr = trap_addr;
    end else if (ex_br_take) begin
      cand_src  = SRC_EX;
      cand_addr = ex_br_addr;
    end else if (id_jmp_take && !load_hazard) begin
      cand_src  = SRC_ID;
      cand_addr = id_jmp_addr;
    end
  end

  assign halt_go = halt_req && !trap_req;

  always_comb begin
    state_d     = state_q;
    pend_src_d  = pend_src_q;
    pend_addr_d = pend_addr_q;
    write       = 1'b0;
    hold        = 1'b0;
    flush       = 2'b00;
    issue_addr  = '0;
    take_new    = 1'b0;
    eff_src     = pend_src_q;
    eff_addr    = pend_addr_q;
    unique case (state_q)
      PRC_RUN: begin
        if (halt_go) begin
          hold    = TRUE;
          state_d = PRC_HALT;
        end else if (cand_src != SRC_NONE) begin
          flush = src_flush(cand_src);
          if (imem_ready) begin
            write      = WRITE_ENABLE;
            issue_addr = cand_addr;
          end else begin
            hold        = TRUE;
            pend_src_d  = cand_src;
            pend_addr_d = cand_addr;
            state_d     = PRC_WAIT;
          end
        end else if (!imem_ready || load_hazard) begin
          hold = TRUE;
        end
      end
      PRC_WAIT: begin
        take_new = !halt_go && (cand_src > pend_src_q);
        if (take_new) begin
          flush    = src_flush(cand_src);
          eff_src  = cand_src;
          eff_addr = cand_addr;
        end
        if (halt_go) begin
          hold    = TRUE;
          state_d = PRC_HALT;
        end else if (imem_ready) begin
          write       = WRITE_ENABLE;
          issue_addr  = eff_addr;
          pend_src_d  = SRC_NONE;
          pend_addr_d = '0;
          state_d     = PRC_RUN;
        end else begin
          hold        = TRUE;
          pend_src_d  = eff_src;
          pend_addr_d = eff_addr;
        end
      end
      PRC_HALT: begin
        hold = TRUE;
        if (resume) begin
          state_d = (pend_src_q != SRC_NONE) ? PRC_WAIT : PRC_RUN;
        end
      end
      default: state_d = PRC_RUN;
    endcase
  end

  pc_target_check #(
    .XLEN         (XLEN),
    .BOOT_ADDR    (BOOT_ADDR),
    .IT_RAM_DEPTH (IT_RAM_DEPTH),
    .TRAP_VEC     (TRAP_VEC)
  ) u_chk (
    .target       (issue_addr),
    .fault        (chk_fault),
    .final_target (chk_target)
  );

  assign pc_write_flag = write;
  assign pc_write_addr = write ? chk_target : '0;
  assign pc_hold       = hold;
  assign flush_if_id   = flush[1];
  assign flush_id_ex   = flush[0];
  assign fault         = write && chk_fault;
  assign fault_addr    = fault ? issue_addr : fault_addr_q;
  assign halted        = (state_q == PRC_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PRC_RUN;
      pend_src_q   <= SRC_NONE;
      pend_addr_q  <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_src_q  <= pend_src_d;
      pend_addr_q <= pend_addr_d;
      if (fault) fault_addr_q <= issue_addr;
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl.
// Honours PC_ALIGN_CHECK_EN for the misaligned-target case.
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_ready;
  logic        load_hazard;
  logic        trap_req;
  logic [31:0] trap_addr;
  logic        ex_br_take;
  logic [31:0] ex_br_addr;
  logic        id_jmp_take;
  logic [31:0] id_jmp_addr;
  logic        halt_req;
  logic        resume;
  logic        pc_write_flag;
  logic [31:0] pc_write_addr;
  logic        pc_hold;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        fault;
  logic [31:0] fault_addr;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  // {write, hold, flush_if_id, flush_id_ex, fault, halted}
  logic [5:0] ctl;
  assign ctl = {pc_write_flag, pc_hold, flush_if_id,
                flush_id_ex, fault, halted};

  pc_redirect_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .imem_ready    (imem_ready),
    .load_hazard   (load_hazard),
    .trap_req      (trap_req),
    .trap_addr     (trap_addr),
    .ex_br_take    (ex_br_take),
    .ex_br_addr    (ex_br_addr),
    .id_jmp_take   (id_jmp_take),
    .id_jmp_addr   (id_jmp_addr),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc_write_flag (pc_write_flag),
    .pc_write_addr (pc_write_addr),
    .pc_hold       (pc_hold),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .fault         (fault),
    .fault_addr    (fault_addr),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    imem_ready  = 1'b1;
    load_hazard = 1'b0;
    trap_req    = 1'b0;
    trap_addr   = '0;
    ex_br_take  = 1'b0;
    ex_br_addr  = '0;
    id_jmp_take = 1'b0;
    id_jmp_addr = '0;
    halt_req    = 1'b0;
    resume      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    @(negedge clk);
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want %b", ctl, 6'b000000);
    end
    n_cmp++;
    if (fault_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_faddr got %h want %h", fault_addr, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_bad++;
      $display("FAIL idle_ctl got %b want %b", ctl, 6'b000000);
    end
    @(negedge clk);
  endtask

  task automatic test_ex_branch();
    ex_br_take = 1'b1;
    ex_br_addr = 32'h40;
    #1;
    n_cmp++;
    if (ctl !== 6'b101100) begin
      n_bad++;
      $display("FAIL ex_ctl got %b want %b", ctl, 6'b101100);
    end
    n_cmp++;
    if (pc_write_addr !== 32'h40) begin
      n_bad++;
      $display("FAIL ex_addr got %h want %h", pc_write_addr, 32'h40);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_bad++;
      $display("FAIL ex_after got %b want %b", ctl, 6'b000000);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_issue();
    imem_ready  = 1'b0;
    id_jmp_take = 1'b1;
    id_jmp_addr = 32'h80;
    #1;
    n_cmp++;
    if (ctl !== 6'b011000) begin
      n_bad++;
      $display("FAIL wait_c1 got %b want %b", ctl, 6'b011000);
    end
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (ctl !== 6'b010000) begin
        n_bad++;
        $display("FAIL wait_c%0d got %b want %b", c, ctl, 6'b010000);
      end
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (ctl !== 6'b100000) begin
      n_bad++;
      $display("FAIL wait_c4 got %b want %b", ctl, 6'b100000);
    end
    n_cmp++;
    if (pc_write_addr !== 32'h80) begin
      n_bad++;
      $display("FAIL wait_addr got %h want %h", pc_write_addr, 32'h80);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_bad++;
      $display("FAIL wait_c5 got %b want %b", ctl, 6'b000000);
    end
    @(negedge clk);
  endtask

  task automatic test_preempt();
    imem_ready  = 1'b0;
    id_jmp_take = 1'b1;
    id_jmp_addr = 32'h80;
    @(negedge clk);
    id_jmp_take = 1'b0;
    trap_req    = 1'b1;
    trap_addr   = 32'h10;
    #1;
    n_cmp++;
    if (ctl !== 6'b011100) begin
      n_bad++;
      $display("FAIL pre_trap got %b want %b", ctl, 6'b011100);
    end
    @(negedge clk);
    trap_req    = 1'b0;
    id_jmp_take = 1'b1;
    id_jmp_addr = 32'h20;
    #1;
    n_cmp++;
    if (ctl !== 6'b010000) begin
      n_bad++;
      $display("FAIL pre_drop got %b want %b", ctl, 6'b010000);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (pc_write_flag !== 1'b1 || pc_write_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL pre_issue got %b/%h want 1/%h",
               pc_write_flag, pc_write_addr, 32'h10);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_bad++;
      $display("FAIL pre_after got %b want %b", ctl, 6'b000000);
    end
    @(negedge clk);
  endtask

  task automatic test_range_fault();
    ex_br_take = 1'b1;
    ex_br_addr = 32'h1000;
    #1;
    n_cmp++;
    if (ctl !== 6'b101110) begin
      n_bad++;
      $display("FAIL rng_ctl got %b want %b", ctl, 6'b101110);
    end
    n_cmp++;
    if (pc_write_addr !== 32'h0 || fault_addr !== 32'h1000) begin
      n_bad++;
      $display("FAIL rng_addr got %h/%h want %h/%h",
               pc_write_addr, fault_addr, 32'h0, 32'h1000);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (fault !== 1'b0 || fault_addr !== 32'h1000) begin
      n_bad++;
      $display("FAIL rng_hold got %b/%h want 0/%h",
               fault, fault_addr, 32'h1000);
    end
    @(negedge clk);
    ex_br_take = 1'b1;
    ex_br_addr = 32'hFFC;
    #1;
    n_cmp++;
    if (ctl !== 6'b101100 || pc_write_addr !== 32'hFFC) begin
      n_bad++;
      $display("FAIL rng_edge got %b/%h want %b/%h",
               ctl, pc_write_addr, 6'b101100, 32'hFFC);
    end
    @(negedge clk);
    ex_br_addr = 32'h42;
    #1;
`ifdef PC_ALIGN_CHECK_EN
    n_cmp++;
    if (ctl !== 6'b101110 || pc_write_addr !== 32'h0 ||
        fault_addr !== 32'h42) begin
      n_bad++;
      $display("FAIL align got %b/%h/%h want %b/%h/%h",
               ctl, pc_write_addr, fault_addr,
               6'b101110, 32'h0, 32'h42);
    end
`else
    n_cmp++;
    if (ctl !== 6'b101100 || pc_write_addr !== 32'h40 ||
        fault_addr !== 32'h1000) begin
      n_bad++;
      $display("FAIL align got %b/%h/%h want %b/%h/%h",
               ctl, pc_write_addr, fault_addr,
               6'b101100, 32'h40, 32'h1000);
    end
`endif
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_load_hazard();
    load_hazard = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b010000) begin
      n_bad++;
      $display("FAIL lh_only got %b want %b", ctl, 6'b010000);
    end
    @(negedge clk);
    id_jmp_take = 1'b1;
    id_jmp_addr = 32'h100;
    #1;
    n_cmp++;
    if (ctl !== 6'b010000) begin
      n_bad++;
      $display("FAIL lh_id got %b want %b", ctl, 6'b010000);
    end
    @(negedge clk);
    id_jmp_take = 1'b0;
    ex_br_take  = 1'b1;
    ex_br_addr  = 32'h200;
    #1;
    n_cmp++;
    if (ctl !== 6'b101100 || pc_write_addr !== 32'h200) begin
      n_bad++;
      $display("FAIL lh_ex got %b/%h want %b/%h",
               ctl, pc_write_addr, 6'b101100, 32'h200);
    end
    @(negedge clk);
    idle();
    id_jmp_take = 1'b1;
    id_jmp_addr = 32'h100;
    #1;
    n_cmp++;
    if (ctl !== 6'b101000 || pc_write_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL lh_resample got %b/%h want %b/%h",
               ctl, pc_write_addr, 6'b101000, 32'h100);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b010000) begin
      n_bad++;
      $display("FAIL halt_req got %b want %b", ctl, 6'b010000);
    end
    @(negedge clk);
    halt_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      trap_req  = c[0];
      trap_addr = 32'h10;
      #1;
      n_cmp++;
      if (ctl !== 6'b010001) begin
        n_bad++;
        $display("FAIL halt_c%0d got %b want %b", c, ctl, 6'b010001);
      end
      @(negedge clk);
    end
    trap_req = 1'b0;
    resume   = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b010001) begin
      n_bad++;
      $display("FAIL resume_cyc got %b want %b", ctl, 6'b010001);
    end
    @(negedge clk);
    resume = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_bad++;
      $display("FAIL resume_run got %b want %b", ctl, 6'b000000);
    end
    @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_bad++;
      $display("FAIL halt_rst got %b want %b", ctl, 6'b000000);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_halt_pending();
    imem_ready  = 1'b0;
    id_jmp_take = 1'b1;
    id_jmp_addr = 32'h80;
    @(negedge clk);
    id_jmp_take = 1'b0;
    halt_req    = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b010000) begin
      n_bad++;
      $display("FAIL hp_req got %b want %b", ctl, 6'b010000);
    end
    @(negedge clk);
    halt_req   = 1'b0;
    imem_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b010001) begin
      n_bad++;
      $display("FAIL hp_halt got %b want %b", ctl, 6'b010001);
    end
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 6'b100000 || pc_write_addr !== 32'h80) begin
      n_bad++;
      $display("FAIL hp_issue got %b/%h want %b/%h",
               ctl, pc_write_addr, 6'b100000, 32'h80);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_wait();
    imem_ready  = 1'b0;
    id_jmp_take = 1'b1;
    id_jmp_addr = 32'h80;
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_bad++;
      $display("FAIL rstw got %b want %b", ctl, 6'b000000);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_bad++;
      $display("FAIL rstw_drop got %b want %b", ctl, 6'b000000);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ex_branch();
    test_wait_issue();
    test_preempt();
    test_range_fault();
    test_load_hazard();
    test_halt();
    test_halt_pending();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
